// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side frame buffer behind the UART receiver.
// Each completed frame {stop_err, parity_err, data} is pushed into a circular
// FIFO on a one-cycle strobe. The host side drains it through a
// first-word-fall-through read port. Fill level, full/empty and a sticky
// overrun flag are reported so that no dropped byte goes unnoticed.
//
// Optional build macro RX_DROP_BAD_FRAMES_EN: frames carrying a parity or
// stop error are discarded instead of stored and are counted in bad_cnt.
// The head error flags are then tied low.
module uart_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,  // power of two, at least 2
   parameter int ADDR_W = 4    // log2(DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_parity_err,
   input  logic              rx_stop_err,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_parity_err,
   output logic              rd_stop_err,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overrun,
`ifdef RX_DROP_BAD_FRAMES_EN
   output logic [7:0]        bad_cnt,
`endif
   input  logic              clr_overrun
);

   localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(DEPTH);

   logic [DATA_W+1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count_nxt;
   logic [DATA_W+1:0] head;
   logic              frame_ok;
   logic              do_wr;
   logic              do_rd;
   logic              drop;

`ifdef RX_DROP_BAD_FRAMES_EN
   assign frame_ok = !(rx_parity_err || rx_stop_err);
`else
   assign frame_ok = 1'b1;
`endif

   // A write is taken while not full, or while full if a read frees the head
   // slot in the same cycle. A read on an empty FIFO is simply ignored.
   assign do_rd = rd_en && !empty;
   assign do_wr = rx_valid && frame_ok && (!full || rd_en);
   assign drop  = rx_valid && frame_ok && full && !rd_en;

   assign empty = (count == '0);
   assign full  = (count == COUNT_FULL);

   // Occupancy update: +1 write-only, -1 read-only, hold otherwise.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      count_nxt = count;
      case ({do_wr, do_rd})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   // Storage array write port.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; empty/count gate every read,
      // so stale contents are never observed and the array maps onto RAM.
      if (do_wr) mem[wr_ptr] <= {rx_stop_err, rx_parity_err, rx_data};
   end

   // Pointers, occupancy and sticky overrun.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its inputs.
      if (!rstn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         if (drop)             overrun <= 1'b1;   // set wins over clear
         else if (clr_overrun) overrun <= 1'b0;
      end
   end

`ifdef RX_DROP_BAD_FRAMES_EN
   // Saturating count of frames discarded for parity/stop errors.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                                bad_cnt <= '0;
      else if (rx_valid && !frame_ok && bad_cnt != 8'hFF)       bad_cnt <= bad_cnt + 1'b1;
   end
`endif

   // First-word-fall-through head, forced to zero while empty.
   assign head    = empty ? '0 : mem[rd_ptr];
   assign rd_data = head[DATA_W-1:0];
`ifdef RX_DROP_BAD_FRAMES_EN
   assign rd_parity_err = 1'b0;
   assign rd_stop_err   = 1'b0;
`else
   assign rd_parity_err = head[DATA_W];
   assign rd_stop_err   = head[DATA_W+1];
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. A queue of expected entries is filled
// as frames are offered and drained as the DUT presents them on the head.
module tb_uart_rx_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rstn;
   logic              rx_valid;
   logic [DATA_W-1:0] rx_data;
   logic              rx_parity_err;
   logic              rx_stop_err;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_parity_err;
   logic              rd_stop_err;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   count;
   logic              overrun;
   logic              clr_overrun;
`ifdef RX_DROP_BAD_FRAMES_EN
   logic [7:0]        bad_cnt;
`endif

   int n_total = 0;
   int n_bad   = 0;

   // Expected entries, {stop, parity, data}, head at index 0.
   logic [DATA_W+1:0] sb[$];

   uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_parity_err (rx_parity_err),
      .rx_stop_err   (rx_stop_err),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .rd_parity_err (rd_parity_err),
      .rd_stop_err   (rd_stop_err),
      .empty         (empty),
      .full          (full),
      .count         (count),
      .overrun       (overrun),
`ifdef RX_DROP_BAD_FRAMES_EN
      .bad_cnt       (bad_cnt),
`endif
      .clr_overrun   (clr_overrun)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of stimulus and update the scoreboard the way the FIFO
   // is expected to react.
   task automatic cycle(input logic wv, input logic [7:0] d, input logic pe,
                        input logic se, input logic re, input logic clr);
      logic accept;
      rx_valid = wv; rx_data = d; rx_parity_err = pe; rx_stop_err = se;
      rd_en = re; clr_overrun = clr;
`ifdef RX_DROP_BAD_FRAMES_EN
      accept = wv && !pe && !se;
`else
      accept = wv;
`endif
      if (re && sb.size() > 0) void'(sb.pop_front());
      if (accept && (sb.size() < DEPTH)) sb.push_back({se, pe, d});
      tick();
      rx_valid = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
      rx_parity_err = 1'b0; rx_stop_err = 1'b0;
   endtask

   // Compare the head with the scoreboard, then consume it.
   task automatic drain_one(input string tag);
      logic [DATA_W+1:0] exp_e;
      exp_e = sb[0];
      n_total++;
      if (rd_data !== exp_e[7:0] || empty !== 1'b0) begin
         n_bad++;
         $display("FAIL %s head: got data=%02h empty=%b, want data=%02h empty=0",
                  tag, rd_data, empty, exp_e[7:0]);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      rstn = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_parity_err = 1'b0;
      rx_stop_err = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
      repeat (2) tick();
      n_total++;
      if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overrun !== 1'b0 ||
          rd_data !== 8'h00 || rd_parity_err !== 1'b0 || rd_stop_err !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: got cnt=%0d e=%b f=%b ovr=%b d=%02h, want 0 1 0 0 00",
                  count, empty, full, overrun, rd_data);
      end
      #2 rstn = 1'b1;
      tick();
   endtask

   task automatic test_single();
      cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (empty !== 1'b0 || count !== 5'd1 || rd_data !== 8'hA5) begin
         n_bad++;
         $display("FAIL single_write: got e=%b cnt=%0d d=%02h, want 0 1 a5", empty, count, rd_data);
      end
      drain_one("single_read");
      n_total++;
      if (empty !== 1'b1 || count !== 5'd0) begin
         n_bad++;
         $display("FAIL single_empty: got e=%b cnt=%0d, want 1 0", empty, count);
      end
      // Read on empty: no effect.
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      n_total++;
      if (empty !== 1'b1 || count !== 5'd0 || overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL read_empty: got e=%b cnt=%0d ovr=%b, want 1 0 0", empty, count, overrun);
      end
      // Write and read together on empty: write wins, count becomes 1.
      cycle(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0);
      n_total++;
      if (count !== 5'd1 || rd_data !== 8'h42) begin
         n_bad++;
         $display("FAIL empty_rw: got cnt=%0d d=%02h, want 1 42", count, rd_data);
      end
      drain_one("empty_rw_read");
   endtask

   task automatic test_fill_drain(input logic [7:0] base);
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (full !== 1'b1 || count !== 5'd16 || rd_data !== base || empty !== 1'b0) begin
         n_bad++;
         $display("FAIL fill_%02h: got f=%b cnt=%0d d=%02h, want 1 16 %02h",
                  base, full, count, rd_data, base);
      end
      while (sb.size() > 0) drain_one("drain");
      n_total++;
      if (empty !== 1'b1 || count !== 5'd0 || full !== 1'b0) begin
         n_bad++;
         $display("FAIL drained_%02h: got e=%b cnt=%0d f=%b, want 1 0 0", base, empty, count, full);
      end
   endtask

   task automatic test_overrun();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (overrun !== 1'b1 || count !== 5'd16) begin
         n_bad++;
         $display("FAIL overrun_set: got ovr=%b cnt=%0d, want 1 16", overrun, count);
      end
      cycle(1'b1, 8'h56, 1'b0, 1'b0, 1'b0, 1'b1);
      n_total++;
      if (overrun !== 1'b1) begin
         n_bad++;
         $display("FAIL overrun_set_wins: got %b, want 1", overrun);
      end
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      n_total++;
      if (overrun !== 1'b0 || count !== 5'd16) begin
         n_bad++;
         $display("FAIL overrun_clear: got ovr=%b cnt=%0d, want 0 16", overrun, count);
      end
      while (sb.size() > 0) drain_one("ovr_drain");
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (rd_data !== 8'h80) begin
         n_bad++;
         $display("FAIL full_rw_head: got %02h, want 80", rd_data);
      end
      cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
      n_total++;
      if (count !== 5'd16 || overrun !== 1'b0 || full !== 1'b1 || rd_data !== 8'h81) begin
         n_bad++;
         $display("FAIL full_rw: got cnt=%0d ovr=%b f=%b d=%02h, want 16 0 1 81",
                  count, overrun, full, rd_data);
      end
      while (sb.size() > 1) drain_one("full_rw_drain");
      n_total++;
      if (rd_data !== 8'h77 || count !== 5'd1) begin
         n_bad++;
         $display("FAIL full_rw_last: got d=%02h cnt=%0d, want 77 1", rd_data, count);
      end
      drain_one("full_rw_last_read");
   endtask

   task automatic test_bad_frame();
      cycle(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef RX_DROP_BAD_FRAMES_EN
      n_total++;
      if (empty !== 1'b1 || count !== 5'd0 || bad_cnt !== 8'd1 || overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL bad_drop: got e=%b cnt=%0d bad=%0d ovr=%b, want 1 0 1 0",
                  empty, count, bad_cnt, overrun);
      end
`else
      n_total++;
      if (rd_stop_err !== 1'b1 || rd_parity_err !== 1'b0 || rd_data !== 8'h3C || count !== 5'd1) begin
         n_bad++;
         $display("FAIL bad_store: got s=%b p=%b d=%02h cnt=%0d, want 1 0 3c 1",
                  rd_stop_err, rd_parity_err, rd_data, count);
      end
      drain_one("bad_read");
      cycle(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (rd_parity_err !== 1'b1 || rd_stop_err !== 1'b0 || rd_data !== 8'hC3) begin
         n_bad++;
         $display("FAIL parity_store: got p=%b s=%b d=%02h, want 1 0 c3",
                  rd_parity_err, rd_stop_err, rd_data);
      end
      drain_one("parity_read");
`endif
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      // Leave the FIFO full-and-overrun free; set overrun via a separate path is
      // not needed here, just confirm the asynchronous clear of occupancy.
      #2 rstn = 1'b0;
      #1;
      sb.delete();
      n_total++;
      if (count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0 || full !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: got cnt=%0d e=%b ovr=%b f=%b, want 0 1 0 0",
                  count, empty, overrun, full);
      end
      @(negedge clk) rstn = 1'b1;
      tick();
      cycle(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
      n_total++;
      if (rd_data !== 8'h99 || count !== 5'd1) begin
         n_bad++;
         $display("FAIL post_reset_write: got d=%02h cnt=%0d, want 99 1", rd_data, count);
      end
      drain_one("post_reset_read");
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain(8'h01);
      test_fill_drain(8'h11);
      test_overrun();
      test_full_rw();
      test_bad_frame();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART receiver top.
- Captures each completed frame (data byte plus parity/stop error flags) on a one-cycle strobe and holds it in a circular FIFO.
- The host/bus side drains it at its own pace with a first-word-fall-through read handshake.
- Reports fill level, full/empty and a sticky overrun flag, so no received byte is silently lost.

Parameters:
- DATA_W, 8, width of received data byte.
- DEPTH, 16, number of entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- rx_valid  input  1  one-cycle strobe: frame complete, rx_data/flags valid this cycle.
- rx_data  input  DATA_W  received byte from receiver.
- rx_parity_err  input  1  parity error flag for this frame.
- rx_stop_err  input  1  stop-bit (framing) error flag for this frame.
- rd_en  input  1  consume head entry; ignored when empty.
- rd_data  output  DATA_W  head entry byte (FWFT).
- rd_parity_err  output  1  head entry parity flag.
- rd_stop_err  output  1  head entry stop flag.
- empty  output  1  no entries.
- full  output  1  DEPTH entries.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overrun  output  1  sticky: a frame was dropped because FIFO was full.
- clr_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rstn low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overrun=0.
  - Storage array is not reset.
  - rd_data/rd_parity_err/rd_stop_err read 0 while empty.
- Storage: each entry is {rx_stop_err, rx_parity_err, rx_data}, DATA_W+2 bits.
- Write:
  - rx_valid=1 and (!full or rd_en=1) writes the entry at wr_ptr.
  - wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
- Read:
  - rd_en=1 and !empty advances rd_ptr modulo DEPTH.
  - rd_data is combinational from mem[rd_ptr], valid whenever empty=0, zero latency (FWFT).
  - The next entry appears the cycle after rd_en.
- Write latency: an entry written into an empty FIFO is visible on rd_data, with empty=0, the cycle after rx_valid.
- count:
  - +1 on write-only, -1 on read-only, unchanged on simultaneous read+write or idle.
  - full = (count==DEPTH); empty = (count==0); both registered/derived from the registered count.
- Simultaneous events:
  - Full with rx_valid and rd_en: both occur, count stays DEPTH, no overrun.
  - Empty with rx_valid and rd_en: write accepted, rd_en ignored, count becomes 1.
  - rd_en while empty: no pointer change, no error.
- Overrun:
  - rx_valid while full and rd_en=0: frame dropped, pointers and contents unchanged, overrun set next cycle.
  - clr_overrun=1 clears it; if set and clear coincide, set wins.
- Reset mid-operation: any in-flight write/read is abandoned and the FIFO returns to empty immediately.
- rx_valid held high for multiple cycles writes one entry per cycle; the upstream side is responsible for a single-cycle strobe.

Optional Feature:
- Macro RX_DROP_BAD_FRAMES_EN.
- Defined:
  - Frames with rx_parity_err=1 or rx_stop_err=1 are never written.
  - They do not count toward overrun.
  - An added output bad_cnt (8 bits, saturating at 255, reset 0) increments once per discarded frame.
  - rd_parity_err/rd_stop_err are tied 0.
- Undefined: all frames are stored with their flags and the bad_cnt port is absent.

Test Plan:
- Reset then write 0xA5 (flags 0) -> the next cycle empty=0, count=1, rd_data=0xA5; rd_en one cycle -> empty=1, count=0.
- Write 0x01..0x10 (16 frames), no reads -> full=1, count=16; rd_data=0x01; drain 16 reads -> bytes 0x01..0x10 in order, then empty=1; pointer wrap verified by a second fill.
- When full, write 0x55 with rd_en=0 -> 0x55 not stored, overrun=1, count=16; assert clr_overrun and rx_valid (still full) on the same cycle -> overrun stays 1; clr_overrun alone -> overrun=0.
- When full, rx_valid=0x77 and rd_en in the same cycle -> count=16, no overrun, 0x77 is the last byte read out after draining.
- Write 0x3C with rx_stop_err=1 -> rd_stop_err=1, rd_data=0x3C; with RX_DROP_BAD_FRAMES_EN -> not stored, empty=1, bad_cnt=1.
- After 5 writes, pulse rstn low asynchronously mid-cycle -> count=0, empty=1, overrun=0 immediately; the next write 0x99 reads back as 0x99.
